fft_rx_frame_ctrl: RTL

Receive-side FFT frame controller for the 8-bin OFDM demodulation path. It configures the FFT core over its AXI-Stream config channel, applies backpressure to the FFT output stream, and checks that each 8-bin symbol arrives complete and in order (tuser 0..7, tlast on bin 7). It pulses `frame_valid` when the downstream serial-to-parallel register bank holds a complete, clean symbol, and it flags and counts malformed symbols for the fault-tolerance monitor.

---
 rtl/fft_rx_frame_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fft_rx_frame_ctrl.sv
// Receive-side FFT frame controller: configures the FFT core, backpressures its output
// stream and checks each symbol for bin order, tlast placement and inter-beat timeout.
module fft_rx_frame_ctrl #(
  parameter int unsigned NFFT    = 8,
  parameter int unsigned IDXW    = 3,
  parameter int unsigned CFG_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [CFG_W-1:0] cfg_word,
  output logic [CFG_W-1:0] cfg_tdata,
  output logic             cfg_tvalid,
  input  logic             cfg_tready,
  input  logic             fft_m_data_tvalid,
  input  logic [IDXW-1:0]  fft_m_data_tuser,
  input  logic             fft_m_data_tlast,
  output logic             fft_m_data_tready,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int unsigned    TW       = $clog2(TIMEOUT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFFT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_WAIT, S_COLLECT} state_t;

  state_t           state_q, state_d;
  logic [CFG_W-1:0] cfg_tdata_q, cfg_tdata_d;
  logic             cfg_tvalid_q, cfg_tvalid_d;
  logic             tready_q, tready_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [IDXW-1:0]  exp_idx_q, exp_idx_d;
  logic [TW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             accept;
  logic             err_hit;
  logic [1:0]       err_sel;

  assign accept = fft_m_data_tvalid && tready_q;

  // Next-state and output decode; every error funnels through err_hit below.
  always_comb begin
    state_d       = state_q;
    cfg_tdata_d   = cfg_tdata_q;
    exp_idx_d     = exp_idx_q;
    idle_cnt_d    = '0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    err_hit       = 1'b0;
    err_sel       = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_tdata_d = cfg_word;
          state_d     = S_CFG;
        end
      end
      S_CFG: begin
        if (cfg_tready) begin
          exp_idx_d = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (accept) begin
          if (fft_m_data_tuser == '0) begin
            exp_idx_d = IDXW'(1);
            state_d   = S_COLLECT;
          end else begin
            err_hit = 1'b1;
            err_sel = 2'd1;
          end
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (fft_m_data_tuser != exp_idx_q) begin
            err_hit = 1'b1;
            err_sel = 2'd1;
          end else if (fft_m_data_tlast != (exp_idx_q == LAST_IDX)) begin
            err_hit = 1'b1;
            err_sel = 2'd3;
          end else if (exp_idx_q == LAST_IDX) begin
            frame_valid_d = 1'b1;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            exp_idx_d = '0;
            state_d   = S_WAIT;
          end else begin
            exp_idx_d = exp_idx_q + IDXW'(1);
          end
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
          if (idle_cnt_d == TW'(TIMEOUT)) begin
            err_hit = 1'b1;
            err_sel = 2'd2;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = err_sel;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      exp_idx_d   = '0;
      idle_cnt_d  = '0;
      state_d     = S_WAIT;
    end

    cfg_tvalid_d = (state_d == S_CFG);
    tready_d     = (state_d == S_WAIT) || (state_d == S_COLLECT);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cfg_tdata_q   <= '0;
      cfg_tvalid_q  <= 1'b0;
      tready_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
      exp_idx_q     <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cfg_tdata_q   <= cfg_tdata_d;
      cfg_tvalid_q  <= cfg_tvalid_d;
      tready_q      <= tready_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
      exp_idx_q     <= exp_idx_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign cfg_tdata         = cfg_tdata_q;
  assign cfg_tvalid        = cfg_tvalid_q;
  assign fft_m_data_tready = tready_q;
  assign frame_valid       = frame_valid_q;
  assign frame_err         = frame_err_q;
  assign err_code          = err_code_q;
  assign busy              = busy_q;
  assign frame_cnt         = frame_cnt_q;
  assign err_cnt           = err_cnt_q;

endmodule
